// File: rtl/div8_share_sched_if.sv
// rtl/div8_share_sched_if.sv - request/response channel between client engines and the divider scheduler
interface div8_share_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_dividend;
    logic [NREQ*W-1:0] req_divisor;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [W-1:0]      rsp_quot;
    logic              rsp_dbz;

    // master: the client side; slave: the scheduler
    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_quot, rsp_dbz
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_quot, rsp_dbz
    );
endinterface

// File: rtl/div8_share_sched.sv
// rtl/div8_share_sched.sv - round-robin scheduler time-sharing one combinational unsigned divider
module div8_share_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int DIV_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    div8_share_sched_if.slave bus,
    output logic [W-1:0]      div_dividend_o,
    output logic [W-1:0]      div_divisor_o,
    input  logic [W-1:0]      div_quot_i,
    output logic              busy_o,
    output logic [15:0]       op_count_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   quot_q, quot_d;
    logic           dbz_q, dbz_d;
    logic [15:0]    op_cnt_q, op_cnt_d;

    logic           grant_vld;
    logic [PW-1:0]  grant_idx;
    logic [PW-1:0]  cand;
    logic [W-1:0]   dvd_sel;
    logic [W-1:0]   dvs_sel;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!grant_vld && bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign dvd_sel = bus.req_dividend[int'(grant_idx)*W +: W];
    assign dvs_sel = bus.req_divisor[int'(grant_idx)*W +: W];

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        dvd_d         = dvd_q;
        dvs_d         = dvs_q;
        cnt_d         = cnt_q;
        quot_d        = quot_q;
        dbz_d         = dbz_q;
        op_cnt_d      = op_cnt_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    bus.req_ready[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    ptr_d   = PW'((int'(grant_idx) + 1) % NREQ);
                    // Zero divisor never reaches the divider, so its operands stay untouched.
                    if (dvs_sel == '0) begin
                        quot_d  = '1;
                        dbz_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        dvd_d   = dvd_sel;
                        dvs_d   = dvs_sel;
                        cnt_d   = CW'(DIV_LAT - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    quot_d  = div_quot_i;
                    dbz_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                bus.rsp_valid[owner_q] = 1'b1;
                if (bus.rsp_ready[owner_q]) begin
                    op_cnt_d = op_cnt_q + 16'd1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            dbz_q    <= 1'b0;
            op_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            dbz_q    <= dbz_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    assign bus.rsp_quot   = quot_q;
    assign bus.rsp_dbz    = dbz_q;
    assign div_dividend_o = dvd_q;
    assign div_divisor_o  = dvs_q;
    assign busy_o         = (state_q != S_IDLE);
    assign op_count_o     = op_cnt_q;
endmodule

// File: tb/tb_div8_share_sched.sv
// tb/tb_div8_share_sched.sv - directed scoreboard bench for div8_share_sched
module tb_div8_share_sched;
    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int DIV_LAT = 2;

    typedef struct {
        int         id;
        logic [7:0] quot;
        logic       dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] div_dividend, div_divisor, div_quot;
    logic         busy;
    logic [15:0]  op_count;
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    exp_t         sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div8_share_sched_if #(.NREQ(NREQ), .W(W)) bus ();

    // External shared divider
    assign div_quot = (div_divisor == '0) ? '1 : W'(div_dividend / div_divisor);

    div8_share_sched #(.NREQ(NREQ), .W(W), .DIV_LAT(DIV_LAT)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .bus            (bus),
        .div_dividend_o (div_dividend),
        .div_divisor_o  (div_divisor),
        .div_quot_i     (div_quot),
        .busy_o         (busy),
        .op_count_o     (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.id   = id;
        e.dbz  = (b == 8'h00);
        e.quot = (b == 8'h00) ? 8'hFF : 8'(a / b);
        sb.push_back(e);
    endtask

    task automatic drive_req(input int id, input logic [7:0] a, input logic [7:0] b);
        bus.req_dividend[id*W +: W] = a;
        bus.req_divisor[id*W +: W]  = b;
        bus.req_valid[id]           = 1'b1;
    endtask

    task automatic accept_one(input int id, input logic [7:0] a, input logic [7:0] b, input bit push);
        int n = 0;
        @(posedge clk); #1;
        drive_req(id, a, b);
        if (push) push_exp(id, a, b);
        @(negedge clk);
        while (!bus.req_ready[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_onehot", 32'(bus.req_ready), 32'(1) << id);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        bus.req_dividend[id*W +: W] = ~a;
        bus.req_divisor[id*W +: W]  = ~b;
    endtask

    task automatic measure_lat(input int exp_lat, input bit chk_div, input logic [7:0] a, input logic [7:0] b);
        int lat = 0;
        @(negedge clk);
        while (bus.rsp_valid == '0 && lat < 20) begin
            if (chk_div) begin
                chk("div_dividend_hold", 32'(div_dividend), 32'(a));
                chk("div_divisor_hold", 32'(div_divisor), 32'(b));
                chk("busy_wait", 32'(busy), 32'd1);
            end
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", lat, exp_lat);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("return_idle", 32'(busy), 32'd0);
    endtask

    // Response monitor: pops one expectation per response handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            chk("ready_rsp_excl", 32'((|bus.req_ready) & (|bus.rsp_valid)), 32'd0);
            if (|(bus.rsp_valid & bus.rsp_ready)) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", 32'(bus.rsp_valid), 32'(1) << e.id);
                    chk("rsp_quot", 32'(bus.rsp_quot), 32'(e.quot));
                    chk("rsp_dbz", 32'(bus.rsp_dbz), 32'(e.dbz));
                end
            end
        end
    end

    initial begin : stim
        int n;
        int last;
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = '1;
        rst_n            = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_quot", 32'(bus.rsp_quot), 32'd0);
        chk("rst_rsp_dbz", 32'(bus.rsp_dbz), 32'd0);
        chk("rst_div_dividend", 32'(div_dividend), 32'd0);
        chk("rst_div_divisor", 32'(div_divisor), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single normal op: 0xC8 / 0x07 = 0x1C
        accept_one(1, 8'hC8, 8'h07, 1'b1);
        measure_lat(DIV_LAT, 1'b1, 8'hC8, 8'h07);
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        chk("single_quot", 32'(bus.rsp_quot), 32'h1C);
        wait_idle();
        chk("op_count_1", 32'(op_count), 32'd1);

        // Divide by zero bypasses the divider
        accept_one(0, 8'h55, 8'h00, 1'b1);
        measure_lat(0, 1'b0, 8'h00, 8'h00);
        chk("dbz_quot", 32'(bus.rsp_quot), 32'hFF);
        chk("dbz_flag", 32'(bus.rsp_dbz), 32'd1);
        chk("dbz_div_dividend_kept", 32'(div_dividend), 32'hC8);
        chk("dbz_div_divisor_kept", 32'(div_divisor), 32'h07);
        wait_idle();
        chk("op_count_2", 32'(op_count), 32'd2);

        // Backpressure on requester 2 while requester 3 waits
        @(posedge clk); #1;
        bus.rsp_ready = 4'b1011;
        drive_req(2, 8'h64, 8'h0A);
        drive_req(3, 8'h90, 8'h03);
        push_exp(2, 8'h64, 8'h0A);
        push_exp(3, 8'h90, 8'h03);
        n = 0;
        @(negedge clk);
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_grant2", 32'(bus.req_ready), 32'h4);
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        measure_lat(DIV_LAT, 1'b1, 8'h64, 8'h0A);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h4);
            chk("bp_rsp_quot", 32'(bus.rsp_quot), 32'h0A);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = '1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_grant3_after", 32'(bus.req_ready), 32'h8);
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        measure_lat(DIV_LAT, 1'b1, 8'h90, 8'h03);
        wait_idle();

        // Round-robin with all requesters continuously valid
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) drive_req(i, 8'hFF, 8'h01);
        for (int i = 0; i < 8; i++) push_exp(i % NREQ, 8'hFF, 8'h01);
        last = 0;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            @(negedge clk);
            while (bus.req_ready == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rr_grant", 32'(bus.req_ready), 32'(1) << (i % NREQ));
            if (i > 0) chk("rr_period", cyc - last, DIV_LAT + 2);
            last = cyc;
            @(posedge clk); #1;
            if (i == 7) bus.req_valid = '0;
        end
        wait_idle();
        chk("rr_drained", sb.size(), 0);

        // op_count wrap
        @(negedge clk);
        force dut.op_cnt_q = 16'hFFFE;
        #1;
        release dut.op_cnt_q;
        accept_one(0, 8'h12, 8'h00, 1'b1);
        measure_lat(0, 1'b0, 8'h00, 8'h00);
        wait_idle();
        chk("op_count_ffff", 32'(op_count), 32'hFFFF);
        accept_one(1, 8'h34, 8'h00, 1'b1);
        measure_lat(0, 1'b0, 8'h00, 8'h00);
        wait_idle();
        chk("op_count_wrap", 32'(op_count), 32'h0000);

        // Reset during WAIT abandons the op
        accept_one(2, 8'h40, 8'h02, 1'b0);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_div_dividend", 32'(div_dividend), 32'd0);
        chk("arst_div_divisor", 32'(div_divisor), 32'd0);
        chk("arst_op_count", 32'(op_count), 32'd0);
        chk("arst_rsp_quot", 32'(bus.rsp_quot), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("post_rst_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 4'b1010;
        @(negedge clk);
        chk("post_rst_ptr0", 32'(bus.req_ready), 32'h2);
        #1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("post_rst_no_accept", 32'(busy), 32'd0);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
